// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling FSM,
// and a small circular receive FIFO drained by a ready/valid consumer.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              serial_in,
  output logic [7:0]                        data_out,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              framing_error,
  output logic                              overflow
);

  localparam int SYM  = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMP = SYM / 2;
  localparam int CNTW = (SYM > 1) ? $clog2(SYM) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);

  localparam logic [CNTW-1:0] SYM_LAST  = CNTW'(SYM - 1);
  localparam logic [CNTW-1:0] SAMP_LAST = CNTW'(SAMP - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic [1:0]      sync_q;
  logic            rx_s;
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, ferr_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ferr_q, ovf_q;
  logic            full, pop, push_ok, ovf_d;

  // Both synchronizer flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNTW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == SAMP_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == SYM_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next start.
        if (cnt_q == SYM_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = data_out_valid && data_out_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_d   = push && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out       = mem_q[rd_ptr_q];
  assign data_out_valid = (count_q != '0);
  assign count          = count_q;
  assign framing_error  = ferr_q;
  assign overflow       = ovf_q;

endmodule
